fft_sample_loader: RTL
======================

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 Parameter SCALE_SHIFT, default 0: arithmetic right-shift (0..7) applied to every accepted sample before storage.
REQ-002 Port clk, input, 1: single clock; all state changes on posedge clk.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port sample_valid, input, 1: upstream presents one complex sample.
REQ-005 Port sample_real, input, `instWidth: signed real part.
REQ-006 Port sample_imag, input, `instWidth: signed imaginary part.
REQ-007 Port ifft_mode, input, 1: 1 = conjugate samples so downstream FFT computes IFFT.
REQ-008 Port sample_ready, output, 1: loader accepts a sample this cycle.
REQ-009 Port butterfly1_ready, input, 1: first butterfly stage's one-cycle completion pulse.
REQ-010 Port fft_data_valid, output, 1: 8-sample frame presented to the first butterfly stage.
REQ-011 Ports fft_dN_real / fft_dN_imag, N=1..8, output, `instWidth each: frame sample N-1 in natural order (d1 = first accepted).
REQ-012 Port loader_busy, output, 1: high whenever state is not FILL or count is nonzero.

Function
REQ-013 States SHALL be FILL, ISSUE and WAIT, with a 3-bit sample counter cnt.
REQ-014 sample_ready SHALL equal 1 in FILL and 0 in ISSUE and WAIT.
REQ-015 Accept: sample_valid & sample_ready in FILL; the processed sample is written to slot cnt+1, then cnt increments.
REQ-016 Acceptance with cnt==7 SHALL wrap cnt to 0 and move to ISSUE on the next edge.
REQ-017 ISSUE SHALL assert fft_data_valid for exactly one cycle, then move to WAIT.
REQ-018 WAIT SHALL return to FILL on the cycle butterfly1_ready==1 (= `funEnable); otherwise it holds WAIT.
REQ-019 sample_valid in ISSUE or WAIT SHALL be ignored, with no storage and no cnt change.
REQ-020 ifft_mode SHALL be latched on acceptance of slot 1 and apply to the whole frame; mid-frame changes are ignored.
REQ-021 Processing order SHALL be: arithmetic shift right by SCALE_SHIFT on both parts, then, if the latched mode is 1, imag = -imag.
REQ-022 Negation of the most negative value (-2^(`instWidth-1)) SHALL saturate to 2^(`instWidth-1)-1.
REQ-023 Output registers SHALL change only on accept, and SHALL hold stable through ISSUE and WAIT.
REQ-024 Minimum frame period SHALL be 8 accept cycles + 1 ISSUE + 2 WAIT = 11 cycles; back-to-back frames SHALL incur no further bubble.

Reset
REQ-025 rst SHALL force state FILL, cnt 0, latched mode 0, fft_data_valid 0, sample_ready 1 (next cycle), loader_busy 0, and all fft_dN outputs 0.
REQ-026 rst mid-frame or in WAIT SHALL discard the partial frame; the next accepted sample lands in slot 1.
REQ-027 rst overrides a simultaneous sample_valid, and that sample is not stored.

Structure
REQ-028 `instWidth, `funEnable and `funDisable SHALL come from the shared define.v; state encodings SHALL be local parameters.
REQ-029 A sub-module sample_cond SHALL perform the shift, conditional conjugation and saturation combinationally; the loader SHALL instantiate it once.

Verification
REQ-030 Eight samples (k, -k), k=1..8, with mode 0 and SCALE_SHIFT 0 -> fft_dN = (N, -N); fft_data_valid pulses once, 1 cycle after the 8th accept.
REQ-031 Same frame with ifft_mode=1 at slot 1 and toggled to 0 at slot 4 -> all imag parts = +N.
REQ-032 Sample imag = 0x80000000 with ifft_mode=1 -> stored imag 0x7FFFFFFF; SCALE_SHIFT=2 and real=-8 -> real -2.
REQ-033 sample_valid held high throughout -> sample_ready drops for ISSUE and WAIT; no sample is lost or duplicated across two consecutive frames; frame period is 11 cycles.
REQ-034 rst after 5 accepts, then 8 new samples -> outputs hold only the new samples, and exactly one fft_data_valid pulse occurs.
REQ-035 butterfly1_ready withheld for 20 cycles -> loader stays in WAIT with sample_ready 0 and outputs stable; FILL resumes on the pulse.

Source files
------------

// File: rtl/fft_sample_loader_pkg.sv
// Shared types and constants for the FFT sample loader.
// The width and enable-level macros normally come from the project-wide
// define.v. The guarded fallbacks below keep this slice self-contained when
// that file is not on the include path.
`ifndef instWidth
`define instWidth 32
`endif
`ifndef funEnable
`define funEnable 1'b1
`endif
`ifndef funDisable
`define funDisable 1'b0
`endif

package fft_sample_loader_pkg;

    localparam int   DATA_W = `instWidth;
    localparam logic FUN_EN = `funEnable;

    localparam logic [1:0] ENC_FILL  = 2'd0;
    localparam logic [1:0] ENC_ISSUE = 2'd1;
    localparam logic [1:0] ENC_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        ST_FILL  = ENC_FILL,
        ST_ISSUE = ENC_ISSUE,
        ST_WAIT  = ENC_WAIT
    } state_t;

endpackage

// File: rtl/fft_sample_loader_sample_cond.sv
// Combinational sample conditioning. Each part is arithmetically scaled.
// The imaginary part is then optionally conjugated. Negation saturates so
// that the most negative code cannot wrap back onto itself.
module sample_cond
    import fft_sample_loader_pkg::*;
#(
    parameter int SCALE_SHIFT = 0
)
(
    input  logic signed [DATA_W-1:0] real_i,
    input  logic signed [DATA_W-1:0] imag_i,
    input  logic                     conj_i,
    output logic signed [DATA_W-1:0] real_o,
    output logic signed [DATA_W-1:0] imag_o
);

    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    function automatic logic signed [DATA_W-1:0] sat_negate(input logic signed [DATA_W-1:0] x);
        if (x == MOST_NEG) begin
            return MOST_POS;
        end
        return -x;
    endfunction

    logic signed [DATA_W-1:0] imag_sh;

    // Shift first, then conjugate, so that saturation acts on the scaled value
    always_comb begin
        real_o  = real_i >>> SCALE_SHIFT;
        imag_sh = imag_i >>> SCALE_SHIFT;
        imag_o  = imag_sh;
        if (conj_i) begin
            imag_o = sat_negate(imag_sh);
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// Collects eight conditioned complex samples into a frame. It issues the
// frame to the first butterfly stage for one cycle. It then holds the frame
// until the butterfly signals completion.
module fft_sample_loader
    import fft_sample_loader_pkg::*;
#(
    parameter int SCALE_SHIFT = 0
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_real,
    input  logic signed [DATA_W-1:0] sample_imag,
    input  logic                     ifft_mode,
    output logic                     sample_ready,
    input  logic                     butterfly1_ready,
    output logic                     fft_data_valid,
    output logic signed [DATA_W-1:0] fft_d1_real,
    output logic signed [DATA_W-1:0] fft_d1_imag,
    output logic signed [DATA_W-1:0] fft_d2_real,
    output logic signed [DATA_W-1:0] fft_d2_imag,
    output logic signed [DATA_W-1:0] fft_d3_real,
    output logic signed [DATA_W-1:0] fft_d3_imag,
    output logic signed [DATA_W-1:0] fft_d4_real,
    output logic signed [DATA_W-1:0] fft_d4_imag,
    output logic signed [DATA_W-1:0] fft_d5_real,
    output logic signed [DATA_W-1:0] fft_d5_imag,
    output logic signed [DATA_W-1:0] fft_d6_real,
    output logic signed [DATA_W-1:0] fft_d6_imag,
    output logic signed [DATA_W-1:0] fft_d7_real,
    output logic signed [DATA_W-1:0] fft_d7_imag,
    output logic signed [DATA_W-1:0] fft_d8_real,
    output logic signed [DATA_W-1:0] fft_d8_imag,
    output logic                     loader_busy
);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic        mode_q;
    logic        conj_d;
    logic        ready_q;
    logic        valid_q;
    logic        busy_q;
    logic        wait_first_q;
    logic        done_seen_q;
    logic        accept;

    logic signed [DATA_W-1:0] re_q [8];
    logic signed [DATA_W-1:0] im_q [8];
    logic signed [DATA_W-1:0] cond_real;
    logic signed [DATA_W-1:0] cond_imag;

    assign accept = sample_valid & ready_q;
    assign cnt_d  = cnt_q + 3'd1;
    // Slot 1 uses the live mode; later slots use the value latched with slot 1
    assign conj_d = (cnt_q == 3'd0) ? ifft_mode : mode_q;

    sample_cond #(.SCALE_SHIFT(SCALE_SHIFT)) u_cond (
        .real_i (sample_real),
        .imag_i (sample_imag),
        .conj_i (conj_d),
        .real_o (cond_real),
        .imag_o (cond_imag)
    );

    // Control FSM: fill eight slots, issue for one cycle, wait for butterfly completion.
    // WAIT lasts at least two cycles. A completion pulse seen in the first
    // WAIT cycle is remembered, and the FSM then returns to FILL at the end of
    // the second WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            cnt_q        <= 3'd0;
            mode_q       <= 1'b0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            wait_first_q <= 1'b0;
            done_seen_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        cnt_q  <= cnt_d;
                        busy_q <= 1'b1;
                        if (cnt_q == 3'd0) begin
                            mode_q <= ifft_mode;
                        end
                        if (cnt_q == 3'd7) begin
                            state_q <= ST_ISSUE;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q      <= ST_WAIT;
                    valid_q      <= 1'b0;
                    wait_first_q <= 1'b1;
                    done_seen_q  <= 1'b0;
                end
                ST_WAIT: begin
                    wait_first_q <= 1'b0;
                    if (!wait_first_q && (done_seen_q || butterfly1_ready == FUN_EN)) begin
                        state_q     <= ST_FILL;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        done_seen_q <= 1'b0;
                    end else if (butterfly1_ready == FUN_EN) begin
                        done_seen_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Frame store: written only on accept, so it holds stable through ISSUE and WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (accept) begin
            re_q[cnt_q] <= cond_real;
            im_q[cnt_q] <= cond_imag;
        end
    end

    assign sample_ready   = ready_q;
    assign fft_data_valid = valid_q;
    assign loader_busy    = busy_q;

    assign fft_d1_real = re_q[0];
    assign fft_d1_imag = im_q[0];
    assign fft_d2_real = re_q[1];
    assign fft_d2_imag = im_q[1];
    assign fft_d3_real = re_q[2];
    assign fft_d3_imag = im_q[2];
    assign fft_d4_real = re_q[3];
    assign fft_d4_imag = im_q[3];
    assign fft_d5_real = re_q[4];
    assign fft_d5_imag = im_q[4];
    assign fft_d6_real = re_q[5];
    assign fft_d6_imag = im_q[5];
    assign fft_d7_real = re_q[6];
    assign fft_d7_imag = im_q[6];
    assign fft_d8_real = re_q[7];
    assign fft_d8_imag = im_q[7];

endmodule
